// File: rtl/irq_pending_reg_pkg.sv
// irq_pending_reg_pkg: shared defaults, FSM state type and counter limit
package irq_pending_reg_pkg;
    localparam int N_DEF  = 8;
    localparam int IW_DEF = 3;
    localparam logic [7:0] LOST_MAX = 8'd255;
    typedef enum logic {IDLE, ASSERT} state_e;
endpackage

// File: rtl/irq_pending_reg_rise.sv
// rise_detect: registered rising-edge detector over an N-bit vector
module rise_detect
    import irq_pending_reg_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] rise
);
    logic [N-1:0] req_q;
    // previous-cycle copy; resetting to 0 makes a line held high across reset count once
    always_ff @(posedge clk) begin
        req_q <= !rst_n ? '0 : d;
    end
    assign rise = d & ~req_q;
endmodule

// File: rtl/irq_pending_reg.sv
// irq_pending_reg: edge capture, pending hold, irq handshake and lost-edge counter
module irq_pending_reg
    import irq_pending_reg_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  pend,
    input  logic [IW-1:0] enc_idx,
    input  logic          enc_v,
    output logic          irq,
    output logic [IW-1:0] irq_id,
    input  logic          ack,
    output logic [7:0]    lost_cnt,
    input  logic          clr_lost
);
    logic [N-1:0]  rise, clr_vec, pending_q, pending_d;
    logic [IW-1:0] irq_id_q, irq_id_d;
    logic [7:0]    lost_q, lost_d;
    logic          irq_q, irq_d, lost;
    state_e        state_q, state_d;

    rise_detect #(.N(N)) u_rise (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (req),
        .rise (rise)
    );

    // pending update with set-over-clear priority and saturating loss count
    always_comb begin
        clr_vec   = (state_q == ASSERT && ack) ? N'(1) << irq_id_q : '0;
        pending_d = rise | (pending_q & ~clr_vec);
        lost      = |(rise & pending_q & ~clr_vec);
        lost_d    = clr_lost ? {7'd0, lost} : (lost && lost_q != LOST_MAX) ? lost_q + 8'd1 : lost_q;
    end

    // service FSM: capture encoder result once, hold it until acknowledged
    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        if (state_q == IDLE) begin
            if (enc_v) begin
                state_d  = ASSERT;
                irq_d    = 1'b1;
                irq_id_d = enc_idx;
            end
        end else if (ack) begin
            state_d = IDLE;
            irq_d   = 1'b0;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
            lost_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
            lost_q    <= lost_d;
        end
    end

    assign pend     = pending_q & mask;
    assign irq      = irq_q;
    assign irq_id   = irq_id_q;
    assign lost_cnt = lost_q;
endmodule

// File: tb/tb_irq_pending_reg.sv
// tb_irq_pending_reg: table vectors, corner sequences and random run against a rule-level model
module tb_irq_pending_reg;
    logic       clk = 1'b0;
    logic       rst_n, ack, clr_lost, enc_v, irq;
    logic [7:0] req, mask, pend, lost_cnt;
    logic [2:0] enc_idx, irq_id;
    int n_chk = 0;
    int n_fail = 0;

    bit [7:0] m_req, m_pend;
    bit       m_irq;
    int       m_id, m_lost;

    typedef struct {
        logic [7:0] req, mask;
        logic       ack, clr, rst_n;
        logic [7:0] e_pend;
        logic       e_irq;
        logic [2:0] e_id;
        logic [7:0] e_lost;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    irq_pending_reg dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mask    (mask),
        .pend    (pend),
        .enc_idx (enc_idx),
        .enc_v   (enc_v),
        .irq     (irq),
        .irq_id  (irq_id),
        .ack     (ack),
        .lost_cnt(lost_cnt),
        .clr_lost(clr_lost)
    );

    // external priority encoder: highest set index wins, junk index when empty
    always_comb begin
        enc_v   = 1'b0;
        enc_idx = 3'd7;
        for (int i = 0; i < 8; i++)
            if (pend[i]) begin
                enc_v   = 1'b1;
                enc_idx = 3'(i);
            end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] r, m, input logic a, c, rn,
                                input logic [7:0] ep, input logic ei, input logic [2:0] eid,
                                input logic [7:0] el);
        vec_t v;
        v.req = r; v.mask = m; v.ack = a; v.clr = c; v.rst_n = rn;
        v.e_pend = ep; v.e_irq = ei; v.e_id = eid; v.e_lost = el;
        return v;
    endfunction

    // one clock: drive, advance model by the stated rules, compare after the edge
    task automatic step(input logic [7:0] r, m, input logic a, c, rn);
        bit [7:0] n_pend;
        bit       n_irq, loss, found;
        int       n_id, n_lost, top;
        req = r; mask = m; ack = a; clr_lost = c; rst_n = rn;
        n_pend = m_pend; n_irq = m_irq; n_id = m_id; loss = 0; found = 0; top = 0;
        for (int i = 0; i < 8; i++) begin
            bit rs, cl;
            rs = r[i] && !m_req[i];
            cl = m_irq && a && (i == m_id);
            if (rs && m_pend[i] && !cl) loss = 1;
            n_pend[i] = rs ? 1'b1 : cl ? 1'b0 : m_pend[i];
            if (m_pend[i] && m[i]) begin found = 1; top = i; end
        end
        if (m_irq) begin
            if (a) n_irq = 0;
        end else if (found) begin
            n_irq = 1; n_id = top;
        end
        n_lost = c ? (loss ? 1 : 0) : loss ? (m_lost < 255 ? m_lost + 1 : 255) : m_lost;
        @(posedge clk);
        #1;
        if (!rn) begin
            m_req = 0; m_pend = 0; m_irq = 0; m_id = 0; m_lost = 0;
        end else begin
            m_req = r; m_pend = n_pend; m_irq = n_irq; m_id = n_id; m_lost = n_lost;
        end
        chk("model_pend", pend, m_pend & m);
        chk("model_irq", irq, m_irq);
        chk("model_irq_id", irq_id, m_id);
        chk("model_lost", lost_cnt, m_lost);
    endtask

    initial begin
        m_req = 0; m_pend = 0; m_irq = 0; m_id = 0; m_lost = 0;
        req = 0; mask = 8'hFF; ack = 0; clr_lost = 0; rst_n = 0;
        step(8'h00, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(8'h00, 8'hFF, 0, 0, 1);
            chk("idle_irq", irq, 0);
            chk("idle_pend", pend, 0);
            chk("idle_lost", lost_cnt, 0);
        end

        //         req    mask   ack clr rn  pend   irq id lost
        tv.push_back(mk(8'h24, 8'hFF, 0, 0, 1, 8'h24, 0, 0, 0));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h24, 1, 5, 0));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h24, 1, 5, 0));
        tv.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h04, 0, 5, 0));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h04, 1, 2, 0));
        tv.push_back(mk(8'h80, 8'hFF, 0, 0, 1, 8'h84, 1, 2, 0));
        tv.push_back(mk(8'h80, 8'hFF, 0, 0, 1, 8'h84, 1, 2, 0));
        tv.push_back(mk(8'h80, 8'hFF, 1, 0, 1, 8'h80, 0, 2, 0));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h80, 1, 7, 0));
        tv.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h00, 0, 7, 0));
        tv.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h00, 0, 7, 0));
        tv.push_back(mk(8'h40, 8'h0F, 0, 0, 1, 8'h00, 0, 7, 0));
        tv.push_back(mk(8'h00, 8'h0F, 0, 0, 1, 8'h00, 0, 7, 0));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h40, 1, 6, 0));
        tv.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h00, 0, 6, 0));
        tv.push_back(mk(8'h08, 8'hFF, 0, 0, 1, 8'h08, 0, 6, 0));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h08, 1, 3, 0));
        tv.push_back(mk(8'h08, 8'hFF, 0, 0, 1, 8'h08, 1, 3, 1));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h08, 1, 3, 1));
        tv.push_back(mk(8'h08, 8'hFF, 0, 0, 1, 8'h08, 1, 3, 2));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h08, 1, 3, 2));
        tv.push_back(mk(8'h08, 8'hFF, 1, 0, 1, 8'h08, 0, 3, 2));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h08, 1, 3, 2));
        tv.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h00, 0, 3, 2));
        tv.push_back(mk(8'h00, 8'hFF, 0, 1, 1, 8'h00, 0, 3, 0));
        tv.push_back(mk(8'h08, 8'hFF, 0, 0, 1, 8'h08, 0, 3, 0));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h08, 1, 3, 0));
        tv.push_back(mk(8'h08, 8'hFF, 0, 1, 1, 8'h08, 1, 3, 1));
        tv.push_back(mk(8'h00, 8'hFF, 0, 1, 1, 8'h08, 1, 3, 0));
        tv.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h00, 0, 3, 0));
        tv.push_back(mk(8'h02, 8'hFF, 0, 0, 1, 8'h02, 0, 3, 0));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h02, 1, 1, 0));
        tv.push_back(mk(8'h02, 8'hFF, 0, 0, 1, 8'h02, 1, 1, 1));
        tv.push_back(mk(8'h01, 8'hFF, 0, 0, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(8'h01, 8'hFF, 0, 0, 1, 8'h01, 0, 0, 0));
        tv.push_back(mk(8'h01, 8'hFF, 0, 0, 1, 8'h01, 1, 0, 0));
        tv.push_back(mk(8'h01, 8'hFF, 1, 0, 1, 8'h00, 0, 0, 0));
        tv.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h00, 0, 0, 0));
        foreach (tv[k]) begin
            step(tv[k].req, tv[k].mask, tv[k].ack, tv[k].clr, tv[k].rst_n);
            chk($sformatf("tv%0d_pend", k), pend, tv[k].e_pend);
            chk($sformatf("tv%0d_irq", k), irq, tv[k].e_irq);
            chk($sformatf("tv%0d_id", k), irq_id, tv[k].e_id);
            chk($sformatf("tv%0d_lost", k), lost_cnt, tv[k].e_lost);
        end

        step(8'h08, 8'hFF, 0, 0, 1);
        step(8'h00, 8'hFF, 0, 0, 1);
        for (int k = 0; k < 260; k++) begin
            step(8'h08, 8'hFF, 0, 0, 1);
            step(8'h00, 8'hFF, 0, 0, 1);
        end
        chk("lost_saturated", lost_cnt, 255);
        chk("sat_irq_held", irq_id, 3);
        step(8'h00, 8'hFF, 1, 1, 1);
        chk("lost_cleared", lost_cnt, 0);
        chk("sat_acked", irq, 0);

        for (int k = 0; k < 3000; k++) begin
            logic [7:0] r, m;
            r = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            step(r, m, $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 199) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
